// File: rtl/reg_cmd_responder.sv
// Byte-framed register access bridge: parses MAGIC-led 8-byte command frames,
// issues one register strobe per frame and returns the 32-bit read value as four reply bytes.
module reg_cmd_responder #(
    parameter logic [7:0] MAGIC      = 8'hAA,
    parameter int         RD_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [7:0]  reply_data,
    output logic        reply_valid,
    input  logic        reply_ready,
    output logic [15:0] reg_addr,
    output logic [31:0] reg_wdata,
    output logic        reg_wr,
    output logic        reg_strobe,
    input  logic [31:0] reg_rdata,
    output logic [3:0]  state_dbg
);

    // Handshakes: a byte moves on a clk edge where valid && ready are both high;
    // the source holds data/valid until that edge, the sink may drop ready at any time.

    typedef enum logic [3:0] {
        HUNT, RX_WR, RX_A0, RX_A1, RX_V0, RX_V1, RX_V2, RX_V3,
        EXEC, WAIT, TX0, TX1, TX2, TX3
    } state_t;

    localparam logic [3:0] LAT = RD_LATENCY[3:0];

    state_t      state, state_n;
    logic [3:0]  lat_cnt, lat_cnt_n;
    logic        wr_s;
    logic [15:0] addr_s;
    logic [23:0] wdata_s;
    logic [31:0] reply_q, reply_n;
    logic [7:0]  reply_data_n;
    logic        accept, tx_go, capture;

    assign accept    = in_valid && in_ready;
    assign tx_go     = reply_valid && reply_ready;
    assign capture   = (state == WAIT) && (lat_cnt == LAT);
    assign state_dbg = state;

    always_comb begin
        state_n   = state;
        lat_cnt_n = lat_cnt;
        unique case (state)
            HUNT:   if (accept && in_data == MAGIC) state_n = RX_WR;
            RX_WR, RX_A0, RX_A1, RX_V0, RX_V1, RX_V2:
                    if (accept) state_n = state_t'(state + 4'd1);
            RX_V3:  if (accept) state_n = EXEC;
            EXEC: begin
                state_n   = WAIT;
                lat_cnt_n = 4'd1;
            end
            WAIT: begin
                if (capture) state_n = TX0;
                else         lat_cnt_n = lat_cnt + 4'd1;
            end
            TX0, TX1, TX2: if (tx_go) state_n = state_t'(state + 4'd1);
            TX3:    if (tx_go) state_n = HUNT;
            default: state_n = HUNT;
        endcase
    end

    // The reply byte is registered, so on the capture edge it must come from reg_rdata itself.
    always_comb begin
        reply_n = capture ? reg_rdata : reply_q;
        unique case (state_n)
            TX0:     reply_data_n = reply_n[7:0];
            TX1:     reply_data_n = reply_n[15:8];
            TX2:     reply_data_n = reply_n[23:16];
            TX3:     reply_data_n = reply_n[31:24];
            default: reply_data_n = 8'h00;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= HUNT;
            lat_cnt     <= 4'd0;
            wr_s        <= 1'b0;
            addr_s      <= 16'h0000;
            wdata_s     <= 24'h000000;
            reply_q     <= 32'h00000000;
            in_ready    <= 1'b1;
            reply_valid <= 1'b0;
            reply_data  <= 8'h00;
            reg_strobe  <= 1'b0;
            reg_wr      <= 1'b0;
            reg_addr    <= 16'h0000;
            reg_wdata   <= 32'h00000000;
        end else begin
            state       <= state_n;
            lat_cnt     <= lat_cnt_n;
            reply_q     <= reply_n;
            in_ready    <= (state_n <= RX_V3);
            reply_valid <= (state_n >= TX0);
            reply_data  <= reply_data_n;
            reg_strobe  <= (state_n == EXEC);
            if (accept) begin
                unique case (state)
                    RX_WR:   wr_s           <= in_data[0];
                    RX_A0:   addr_s[7:0]    <= in_data;
                    RX_A1:   addr_s[15:8]   <= in_data;
                    RX_V0:   wdata_s[7:0]   <= in_data;
                    RX_V1:   wdata_s[15:8]  <= in_data;
                    RX_V2:   wdata_s[23:16] <= in_data;
                    default: ;
                endcase
            end
            // Register-side fields only move at the EXEC edge so they stay stable for the whole access.
            if (accept && state == RX_V3) begin
                reg_wr    <= wr_s;
                reg_addr  <= addr_s;
                reg_wdata <= {in_data, wdata_s};
            end
        end
    end

endmodule

// File: tb/tb_reg_cmd_responder.sv
// Directed frame bench for reg_cmd_responder: stimulus pushes expected strobes and reply
// bytes into queues, negedge monitors pop and compare as the DUT produces them.
module tb_reg_cmd_responder;

    localparam int          LAT  = 3;
    localparam logic [31:0] BASE = 32'hC0DE0000;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  reply_data;
    logic        reply_valid;
    logic        reply_ready;
    logic [15:0] reg_addr;
    logic [31:0] reg_wdata;
    logic        reg_wr;
    logic        reg_strobe;
    logic [31:0] reg_rdata;
    logic [3:0]  state_dbg;

    logic [31:0] cyc = 32'd0;
    logic        rdata_mode = 1'b0;
    logic [31:0] rdata_const = 32'd0;
    logic        stall_req = 1'b0;
    logic [1:0]  rx_idx = 2'd0;
    logic        chk_ready_next = 1'b0;

    logic [7:0]  exp_q[$];
    logic [48:0] exp_s_q[$];
    int          checks = 0;
    int          failures = 0;

    reg_cmd_responder #(.MAGIC(8'hAA), .RD_LATENCY(LAT)) dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .reply_data(reply_data), .reply_valid(reply_valid),
        .reply_ready(reply_ready), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
        .reg_wr(reg_wr), .reg_strobe(reg_strobe), .reg_rdata(reg_rdata),
        .state_dbg(state_dbg)
    );

    // clock / register model
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 32'd1;
    assign reg_rdata = rdata_mode ? (BASE + cyc) : rdata_const;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_in_ready"},    64'(in_ready),    64'd1);
        chk({tag, "_reply_valid"}, 64'(reply_valid), 64'd0);
        chk({tag, "_reply_data"},  64'(reply_data),  64'd0);
        chk({tag, "_reg_strobe"},  64'(reg_strobe),  64'd0);
        chk({tag, "_reg_wr"},      64'(reg_wr),      64'd0);
        chk({tag, "_reg_addr"},    64'(reg_addr),    64'd0);
        chk({tag, "_reg_wdata"},   64'(reg_wdata),   64'd0);
        chk({tag, "_state"},       64'(state_dbg),   64'd0);
    endtask

    // driver tasks
    task automatic send_byte(input logic [7:0] b);
        bit done = 1'b0;
        @(negedge clk);
        in_data  = b;
        in_valid = 1'b1;
        for (int t = 0; t < 400 && !done; t++) begin
            done = in_ready;
            @(posedge clk);
            if (!done) @(negedge clk);
        end
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL send_timeout actual=in_ready_low required=byte_%0h_accepted", b);
        end
    endtask

    task automatic send_frame(input logic [7:0] wr_byte, input logic [15:0] addr,
                              input logic [31:0] wdata, input logic mode,
                              input logic [31:0] rconst, input logic [31:0] exp_reply);
        logic [31:0] r;
        exp_s_q.push_back({wr_byte[0], addr, wdata});
        send_byte(8'hAA);
        send_byte(wr_byte);
        send_byte(addr[7:0]);
        send_byte(addr[15:8]);
        send_byte(wdata[7:0]);
        send_byte(wdata[15:8]);
        send_byte(wdata[23:16]);
        send_byte(wdata[31:24]);
        @(negedge clk);
        // This negedge is in the strobe cycle; the reply samples reg_rdata LAT cycles later.
        rdata_mode  = mode;
        rdata_const = rconst;
        r = mode ? (BASE + cyc + LAT) : exp_reply;
        exp_q.push_back(r[7:0]);
        exp_q.push_back(r[15:8]);
        exp_q.push_back(r[23:16]);
        exp_q.push_back(r[31:24]);
    endtask

    // reply back-pressure driver
    initial begin
        reply_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (stall_req && rx_idx == 2'd1 && reply_ready) begin
                reply_ready = 1'b0;
                repeat (10) @(posedge clk);
                #1;
                reply_ready = 1'b1;
                stall_req   = 1'b0;
            end
        end
    end

    // scoreboard monitor
    always @(negedge clk) begin
        if (!reset) begin
            if (reg_strobe) begin
                if (exp_s_q.size() == 0) begin
                    chk("unexpected_strobe", {15'd0, reg_wr, reg_addr, reg_wdata}, 64'h0);
                end else begin
                    chk("strobe_fields", {15'd0, reg_wr, reg_addr, reg_wdata},
                        {15'd0, exp_s_q.pop_front()});
                end
            end
            if (reply_valid) begin
                chk("in_ready_during_reply", 64'(in_ready), 64'd0);
                if (exp_q.size() == 0) begin
                    chk("unexpected_reply", 64'(reply_data), 64'h100);
                end else begin
                    chk("reply_byte", 64'(reply_data), 64'(exp_q[0]));
                    if (reply_ready) begin
                        void'(exp_q.pop_front());
                        if (rx_idx == 2'd3) chk_ready_next = 1'b1;
                        rx_idx = rx_idx + 2'd1;
                    end
                end
            end else if (chk_ready_next) begin
                chk("in_ready_after_tx3", 64'(in_ready), 64'd1);
                chk_ready_next = 1'b0;
            end
        end
    end

    // main sequence
    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (3) @(negedge clk);
        check_reset_outputs("por");
        reset = 1'b0;

        // noise then a read of address 1 returning 3
        send_byte(8'hFF);
        send_byte(8'hFF);
        send_byte(8'hFF);
        send_frame(8'h00, 16'h0001, 32'h00000000, 1'b0, 32'h00000003, 32'h00000003);
        // write 4 to address 3
        send_frame(8'h01, 16'h0003, 32'h00000004, 1'b0, 32'h12345678, 32'h12345678);
        // read with upper wr-byte bits set and a changing reg_rdata
        send_frame(8'hFE, 16'h2010, 32'h00000000, 1'b1, 32'h00000000, 32'h00000000);
        // back-pressure on the in-flight reply's second byte
        stall_req = 1'b1;
        send_frame(8'h00, 16'h1234, 32'h00000000, 1'b0, 32'hA1B2C3D4, 32'hA1B2C3D4);

        // aborted frame: reset once the address bytes are in
        send_byte(8'hAA);
        send_byte(8'h00);
        send_byte(8'h05);
        send_byte(8'h00);
        @(negedge clk);
        in_valid = 1'b0;
        reset    = 1'b1;
        #1;
        check_reset_outputs("async_rst");
        repeat (2) @(negedge clk);
        reset = 1'b0;

        send_frame(8'h01, 16'h5678, 32'hDEADBEEF, 1'b0, 32'h0BADF00D, 32'h0BADF00D);
        // MAGIC bytes inside the payload
        send_frame(8'h01, 16'hAAAA, 32'hAAAAAAAA, 1'b0, 32'h5A5A0FF0, 32'h5A5A0FF0);
        @(negedge clk);
        in_valid = 1'b0;

        for (int t = 0; t < 500 && (exp_q.size() != 0 || exp_s_q.size() != 0); t++)
            @(negedge clk);
        chk("pending_reply_bytes", 64'(exp_q.size()), 64'd0);
        chk("pending_strobes", 64'(exp_s_q.size()), 64'd0);
        repeat (5) @(negedge clk);
        chk("final_reply_valid", 64'(reply_valid), 64'd0);
        chk("final_in_ready", 64'(in_ready), 64'd1);
        chk("held_reg_addr", 64'(reg_addr), 64'hAAAA);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
